data_mem_responder: RTL and testbench

//   Data-memory responder for the RISC-V core's load/store port. It accepts one

---
 rtl/data_mem_responder.sv | 158 +++++++++++++++
 tb/tb_data_mem_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Load/store responder for the core's data port: accepts one request, waits a
// programmable number of cycles, then returns extended read data or an error.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_size,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state, state_nxt;
  logic [3:0]         cnt;
  logic               we_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [2:0]         size_q;
  logic [31:0]        mem [DEPTH_WORDS];

  logic               accept;
  logic               do_access;
  logic               acc_we;
  logic [31:0]        acc_addr;
  logic [31:0]        acc_wdata;
  logic [2:0]         acc_size;
  logic [31:0]        off;
  logic [IDX_W-1:0]   idx;
  logic               acc_e;
  logic [31:0]        rd_word;

  function automatic logic access_err(input logic we, input logic [31:0] o,
                                      input logic [2:0] size);
    logic e;
    e = (o >= SPAN);
    case (size)
      3'b000, 3'b100: ;
      3'b001, 3'b101: if (o[0]) e = 1'b1;
      3'b010:         if (o[1:0] != 2'b00) e = 1'b1;
      default:        e = 1'b1;
    endcase
    if (we && size[2]) e = 1'b1;
    return e;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] lane,
                                           input logic [2:0] size);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] lane, input logic [2:0] size);
    logic [31:0] w;
    w = old;
    case (size)
      3'b000:  w[{lane, 3'b000} +: 8] = wd[7:0];
      3'b001:  if (lane[1]) w[31:16] = wd[15:0]; else w[15:0] = wd[15:0];
      3'b010:  w = wd;
      default: ;
    endcase
    return w;
  endfunction

  // With zero latency the access uses the live request; otherwise the latched copy.
  always_comb begin
    acc_we    = (state == IDLE) ? req_we    : we_q;
    acc_addr  = (state == IDLE) ? req_addr  : addr_q;
    acc_wdata = (state == IDLE) ? req_wdata : wdata_q;
    acc_size  = (state == IDLE) ? req_size  : size_q;
    off       = acc_addr - BASE_ADDR;
    idx       = off[IDX_W+1:2];
    acc_e     = access_err(acc_we, off, acc_size);
    rd_word   = mem[idx];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // cnt holds the wait cycles still to spend in WAIT before the access edge.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = (LAT == 4'd0) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) && !rst;
    rsp_valid = (state == RESP);
    accept    = req_ready && req_valid;
    do_access = !rst && ((accept && (LAT == 4'd0)) || ((state == WAIT) && (cnt == 4'd0)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (accept) begin
      cnt <= LAT;
    end else if ((state == WAIT) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      size_q  <= req_size;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else if (do_access) begin
      rsp_err   <= acc_e;
      rsp_rdata <= (acc_e || acc_we) ? 32'h0 : load_ext(rd_word, off[1:0], acc_size);
    end
  end

  always_ff @(posedge clk) begin
    if (do_access && acc_we && !acc_e)
      mem[idx] <= store_merge(rd_word, acc_wdata, off[1:0], acc_size);
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: LATENCY=2 instance for access and
// handshake behaviour, LATENCY=0 instance for back-to-back streaming.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_size = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        z_req_valid = 1'b0, z_req_we = 1'b0, z_rsp_ready = 1'b0;
  logic [31:0] z_req_addr = '0, z_req_wdata = '0;
  logic [2:0]  z_req_size = '0;
  logic        z_req_ready, z_rsp_valid, z_rsp_err;
  logic [31:0] z_rsp_rdata;

  int errs   = 0;
  int checks = 0;

  logic [31:0] ztab [4] = '{32'h1111_1111, 32'hA5A5_A5A5, 32'h0BAD_F00D, 32'hCAFE_BABE};

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(0), .BASE_ADDR(32'h0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_size(z_req_size),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request and return #1 after the edge that accepts it.
  task automatic accept(input logic we, input logic [31:0] a, input logic [31:0] w,
                        input logic [2:0] sz);
    int n;
    n = 0;
    @(negedge clk);
    req_we = we; req_addr = a; req_wdata = w; req_size = sz; req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic take();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic xfer(input string tag, input logic we, input logic [31:0] a,
                      input logic [31:0] w, input logic [2:0] sz,
                      input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    accept(we, a, w, sz);
    wait_rsp(lat);
    chk({tag, "_lat"}, lat, 32'd3);
    chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    chk({tag, "_rd"}, rsp_rdata, exp_rd);
    take();
  endtask

  task automatic stream(input string tag, input logic we);
    int          i;
    int          nrsp;
    logic        acc;
    logic [31:0] got [4];
    i = 0;
    nrsp = 0;
    z_req_we = we; z_req_size = 3'b010; z_req_addr = 32'h0; z_req_wdata = ztab[0];
    z_req_valid = 1'b1; z_rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      acc = z_req_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        i++;
        if (i < 4) begin
          z_req_addr  = 32'(i * 4);
          z_req_wdata = ztab[i];
        end else begin
          z_req_valid = 1'b0;
        end
      end
      chk({tag, "_vld"}, {31'd0, z_rsp_valid}, {31'd0, (c % 2 == 0)});
      if (z_rsp_valid && nrsp < 4) begin
        got[nrsp] = z_rsp_rdata;
        nrsp++;
      end
    end
    z_rsp_ready = 1'b0;
    chk({tag, "_count"}, nrsp, 32'd4);
    for (int k = 0; k < 4; k++)
      chk({tag, "_rd"}, (k < nrsp) ? got[k] : 32'hXXXX_XXXX, we ? 32'h0 : ztab[k]);
  endtask

  initial begin
    int lat;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b0;
    #1 chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    xfer("sw10", 1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, 32'h0, 1'b0);
    xfer("lw10", 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD_BEEF, 1'b0);

    xfer("sb13", 1'b1, 32'h13, 32'h0000_0080, 3'b000, 32'h0, 1'b0);
    xfer("lb13", 1'b0, 32'h13, 32'h0, 3'b000, 32'hFFFF_FF80, 1'b0);
    xfer("lbu13", 1'b0, 32'h13, 32'h0, 3'b100, 32'h0000_0080, 1'b0);
    xfer("lh12", 1'b0, 32'h12, 32'h0, 3'b001, 32'hFFFF_80AD, 1'b0);
    xfer("lhu12", 1'b0, 32'h12, 32'h0, 3'b101, 32'h0000_80AD, 1'b0);
    xfer("lw10b", 1'b0, 32'h10, 32'h0, 3'b010, 32'h80AD_BEEF, 1'b0);

    xfer("lw12_mis", 1'b0, 32'h12, 32'h0, 3'b010, 32'h0, 1'b1);
    xfer("sh11_mis", 1'b1, 32'h11, 32'h0000_AAAA, 3'b001, 32'h0, 1'b1);
    xfer("sbu_store", 1'b1, 32'h10, 32'h0000_0055, 3'b100, 32'h0, 1'b1);
    xfer("lw10_keep", 1'b0, 32'h10, 32'h0, 3'b010, 32'h80AD_BEEF, 1'b0);
    xfer("lw400_oor", 1'b0, 32'h400, 32'h0, 3'b010, 32'h0, 1'b1);
    xfer("size011", 1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1);
    xfer("sw3fc", 1'b1, 32'h3FC, 32'h0102_0304, 3'b010, 32'h0, 1'b0);
    xfer("lw3fc", 1'b0, 32'h3FC, 32'h0, 3'b010, 32'h0102_0304, 1'b0);

    accept(1'b0, 32'h10, 32'h0, 3'b010);
    wait_rsp(lat);
    for (int k = 0; k < 5; k++) begin
      chk("hold_vld", {31'd0, rsp_valid}, 32'd1);
      chk("hold_rd", rsp_rdata, 32'h80AD_BEEF);
      chk("hold_rdy", {31'd0, req_ready}, 32'd0);
      if (k == 2) begin
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h5555; req_size = 3'b010;
        req_valid = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    take();
    for (int k = 0; k < 6; k++) begin
      chk("no_extra_rsp", {31'd0, rsp_valid}, 32'd0);
      @(posedge clk);
      #1;
    end

    xfer("sw20", 1'b1, 32'h20, 32'h0000_1234, 3'b010, 32'h0, 1'b0);
    xfer("lw20", 1'b0, 32'h20, 32'h0, 3'b010, 32'h0000_1234, 1'b0);
    accept(1'b1, 32'h20, 32'h0000_FFFF, 3'b010);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_vld", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_rd", rsp_rdata, 32'd0);
    chk("midrst_err", {31'd0, rsp_err}, 32'd0);
    chk("midrst_rdy", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    #1 chk("midrst_rdy_rel", {31'd0, req_ready}, 32'd1);
    xfer("lw20_after", 1'b0, 32'h20, 32'h0, 3'b010, 32'h0000_1234, 1'b0);

    stream("z_st", 1'b1);
    stream("z_ld", 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
